pll_reconfig_seq: RTL and testbench
===================================

// Module: pll_reconfig_seq
// PURPOSE
//  Sequencer that reprograms a reconfigurable PLL at run time.
//  Takes one complete PLL setting per handshake: N, M, fractional K and up to NUM_CLOCKS C counters.
//  Writes the setting through the Avalon-MM management port of the PLL reconfiguration core, starts it, then supervises relock.
//  Sits between fabric/HPS control logic and the PLL reconfig_to_pll/reconfig_from_pll pair.
// PARAMETERS
//  NUM_CLOCKS    4      number of PLL output counters handled, 1..18
//  USE_FRAC      1      1: write K register (addr 0x07); 0: skip K write
//  SETTLE_CYC    16     cycles after START during which pll_locked is ignored, >=1
//  LOCK_TIMEOUT  65535  max cycles after settle to see pll_locked=1, >=1
// PORTS
//  refclk            in   1              management clock, all logic rising-edge
//  rst               in   1              synchronous reset, active-high
//  cfg_valid         in   1              setting offered
//  cfg_ready         out  1              setting accepted when cfg_valid&cfg_ready
//  cfg_n             in   18             N word: [17]odd [16]bypass [15:8]hi [7:0]lo
//  cfg_m             in   18             M word, same format
//  cfg_k             in   32             fractional K
//  cfg_c             in   18*NUM_CLOCKS  C word per channel i at [18*i+:18], same format
//  cfg_c_mask        in   NUM_CLOCKS     1 = write counter i
//  mgmt_address      out  6              Avalon-MM address to reconfig core
//  mgmt_write        out  1              Avalon-MM write
//  mgmt_writedata    out  32             Avalon-MM write data
//  mgmt_waitrequest  in   1              Avalon-MM waitrequest
//  pll_locked        in   1              PLL locked (asynchronous to refclk)
//  busy              out  1              sequence in progress
//  done              out  1              one-cycle pulse at end of sequence
//  error             out  1              lock timeout; valid with done, held until next accept
// BEHAVIOUR
//  Reset: cfg_ready=0 during rst and 1 the cycle after.
//  Reset: mgmt_write=0, mgmt_address=0, mgmt_writedata=0, busy=0, done=0, error=0.
//  Reset mid-sequence: return to IDLE next cycle with mgmt_write dropped immediately; the setting is discarded.
//  pll_locked: double-flop synchronised; adds 2 cycles of latency.
//  cfg_ready = (state==IDLE). Accept captures all cfg_* into registers.
//  On accept: cfg_* changes are ignored until the next accept; clear error; raise busy.
//  States and transitions:
//   IDLE      -> WR_MODE on accept
//   WR_MODE   addr 0x00 data 0 (waitrequest mode) -> WR_N
//   WR_N      addr 0x03 data {14'b0,n} -> WR_M
//   WR_M      addr 0x04 data {14'b0,m} -> WR_K if USE_FRAC else WR_C
//   WR_K      addr 0x07 data k -> WR_C
//   WR_C      addr 0x05 data {9'b0, idx[4:0], c[idx]}, for each set mask bit in ascending idx
//             -> WR_START after the last set bit; an all-zero mask goes straight to WR_START
//   WR_START  addr 0x02 data 1 -> SETTLE
//   SETTLE    count SETTLE_CYC cycles -> LOCKWAIT
//   LOCKWAIT  synced locked=1 -> DONE (error=0)
//             LOCK_TIMEOUT cycles elapsed without lock -> DONE (error=1)
//   DONE      done=1 for one cycle, busy=0 -> IDLE
//  Write handshake:
//   mgmt_write held with stable address/data until a cycle where mgmt_write & !mgmt_waitrequest.
//   The state advances on that edge.
//   Consecutive writes are back-to-back: next write asserted the cycle after acceptance.
//   Minimum one cycle per write.
//  mgmt_write=0 in IDLE, SETTLE, LOCKWAIT and DONE.
//  busy=1 from the cycle after accept through LOCKWAIT.
//  Latency, waitrequest=0, USE_FRAC=1, j mask bits set: START accepted 5+j cycles after accept.
//  Timeout counter: width clog2(LOCK_TIMEOUT+1); no wrap, saturates at terminal count.
//  pll_locked sampled only in LOCKWAIT; a glitch in SETTLE has no effect.
// TESTING
//  1 NUM_CLOCKS=4, mask 4'b0101, waitrequest=0, locked rises 5 cycles into LOCKWAIT
//    -> addr seq 00,03,04,07,05,05,02; C data idx 0 then 2; done=1, error=0.
//  2 waitrequest held 3 cycles on each write -> each write stable 4 cycles; order and data unchanged.
//  3 locked stuck 0, LOCK_TIMEOUT=100 -> done 100 cycles after LOCKWAIT entry with error=1.
//    Next accept clears error.
//  4 mask=0, USE_FRAC=0 -> addr seq 00,03,04,02 only.
//  5 rst asserted during 2nd C write -> next cycle mgmt_write=0, busy=0, cfg_ready=1, no done pulse.
//  6 cfg_valid held high throughout -> second setting accepted only in cycle after done.
//    cfg_* changes mid-sequence do not alter writedata.

Source files
------------

// File: rtl/pll_reconfig_seq_if.sv
// Purpose : bundles the setting handshake and the Avalon-MM management bus of the PLL reconfig sequencer.
// Latency : none, wires only.
// Backpressure: cfg_valid/cfg_ready handshake on the setting side; mgmt_waitrequest stalls the write side.
interface pll_reconfig_seq_if #(
    parameter int NUM_CLOCKS = 4
);
    // Setting handshake from fabric/HPS control logic
    logic                       cfg_valid;
    logic                       cfg_ready;
    logic [17:0]                cfg_n;
    logic [17:0]                cfg_m;
    logic [31:0]                cfg_k;
    logic [18*NUM_CLOCKS-1:0]   cfg_c;
    logic [NUM_CLOCKS-1:0]      cfg_c_mask;

    // Avalon-MM management port towards the PLL reconfiguration core
    logic [5:0]                 mgmt_address;
    logic                       mgmt_write;
    logic [31:0]                mgmt_writedata;
    logic                       mgmt_waitrequest;

    // Environment side: offers settings and plays the reconfig core.
    modport master (
        output cfg_valid, cfg_n, cfg_m, cfg_k, cfg_c, cfg_c_mask, mgmt_waitrequest,
        input  cfg_ready, mgmt_address, mgmt_write, mgmt_writedata
    );

    // Sequencer side.
    modport slave (
        input  cfg_valid, cfg_n, cfg_m, cfg_k, cfg_c, cfg_c_mask, mgmt_waitrequest,
        output cfg_ready, mgmt_address, mgmt_write, mgmt_writedata
    );
endinterface

// File: rtl/pll_reconfig_seq.sv
// Purpose : writes one PLL setting (N, M, K, masked C counters) to the reconfig core, starts it and supervises relock.
// Latency : START write accepted 5+j cycles after accept (no waitrequest, K written, j counters); then SETTLE_CYC + lock wait.
// Backpressure: cfg_ready only in IDLE; each management write holds address/data until waitrequest is low.
module pll_reconfig_seq #(
    parameter int NUM_CLOCKS   = 4,
    parameter int USE_FRAC     = 1,
    parameter int SETTLE_CYC   = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic              refclk,
    input  logic              rst,
    pll_reconfig_seq_if.slave bus,
    input  logic              pll_locked,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] TO_MAX      = TW'(LOCK_TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_MODE, S_WR_N, S_WR_M, S_WR_K, S_WR_C,
        S_WR_START, S_SETTLE, S_LOCKWAIT, S_DONE
    } state_t;

    state_t                     r_state;
    logic [17:0]                r_n;
    logic [17:0]                r_m;
    logic [31:0]                r_k;
    logic [18*NUM_CLOCKS-1:0]   r_c;
    logic [NUM_CLOCKS-1:0]      r_mask;      // counters still to be written
    logic [SW-1:0]              r_scnt;
    logic [TW-1:0]              r_tcnt;
    logic                       r_error;
    logic                       r_lk_meta;
    logic                       r_lk_sync;

    state_t                     w_next;
    state_t                     w_wr_next;   // target once the current write is taken
    logic                       w_write;
    logic [5:0]                 w_addr;
    logic [31:0]                w_data;
    logic                       w_busy;
    logic                       w_done;
    logic                       w_ready;
    logic                       w_accept;
    logic                       w_wr_ack;
    logic [4:0]                 w_idx;
    logic [17:0]                w_c_word;
    logic [NUM_CLOCKS-1:0]      w_mask_rest;

    assign w_accept    = w_ready & bus.cfg_valid & ~rst;
    assign w_wr_ack    = w_write & ~bus.mgmt_waitrequest;
    // Clearing the lowest set bit walks the mask in ascending channel order.
    assign w_mask_rest = r_mask & (r_mask - NUM_CLOCKS'(1));
    assign w_c_word    = r_c[18*w_idx +: 18];

    // Lowest pending counter index (descending scan leaves the smallest hit).
    always_comb begin
        w_idx = '0;
        for (int i = NUM_CLOCKS - 1; i >= 0; i--) begin
            if (r_mask[i]) w_idx = 5'(i);
        end
    end

    // Next state and Moore outputs; write states advance only when the write is taken.
    always_comb begin
        w_next    = r_state;
        w_wr_next = r_state;
        w_write   = 1'b0;
        w_addr    = 6'h00;
        w_data    = 32'd0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.cfg_valid) w_next = S_WR_MODE;
            end
            S_WR_MODE: begin
                w_write   = 1'b1;
                w_addr    = 6'h00;
                w_data    = 32'd0;
                w_wr_next = S_WR_N;
            end
            S_WR_N: begin
                w_write   = 1'b1;
                w_addr    = 6'h03;
                w_data    = {14'b0, r_n};
                w_wr_next = S_WR_M;
            end
            S_WR_M: begin
                w_write   = 1'b1;
                w_addr    = 6'h04;
                w_data    = {14'b0, r_m};
                if (USE_FRAC != 0)  w_wr_next = S_WR_K;
                else if (|r_mask)   w_wr_next = S_WR_C;
                else                w_wr_next = S_WR_START;
            end
            S_WR_K: begin
                w_write   = 1'b1;
                w_addr    = 6'h07;
                w_data    = r_k;
                w_wr_next = (|r_mask) ? S_WR_C : S_WR_START;
            end
            S_WR_C: begin
                w_write   = 1'b1;
                w_addr    = 6'h05;
                w_data    = {9'b0, w_idx, w_c_word};
                w_wr_next = (|w_mask_rest) ? S_WR_C : S_WR_START;
            end
            S_WR_START: begin
                w_write   = 1'b1;
                w_addr    = 6'h02;
                w_data    = 32'd1;
                w_wr_next = S_SETTLE;
            end
            S_SETTLE: begin
                w_busy = 1'b1;
                if (r_scnt == SETTLE_LAST) w_next = S_LOCKWAIT;
            end
            S_LOCKWAIT: begin
                w_busy = 1'b1;
                if (r_lk_sync)               w_next = S_DONE;
                else if (r_tcnt == TO_LAST)  w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_write) begin
            w_busy = 1'b1;
            if (!bus.mgmt_waitrequest) w_next = w_wr_next;
        end
    end

    // Outputs are forced quiet while reset is high so a write in flight drops at once.
    assign bus.cfg_ready      = w_ready & ~rst;
    assign bus.mgmt_write     = w_write & ~rst;
    assign bus.mgmt_address   = rst ? 6'h00 : w_addr;
    assign bus.mgmt_writedata = rst ? 32'd0 : w_data;
    assign busy               = w_busy & ~rst;
    assign done               = w_done & ~rst;
    assign error              = r_error & ~rst;

    // State register.
    always_ff @(posedge refclk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Setting capture on accept; input changes afterwards are ignored.
    always_ff @(posedge refclk) begin
        if (w_accept) begin
            r_n <= bus.cfg_n;
            r_m <= bus.cfg_m;
            r_k <= bus.cfg_k;
            r_c <= bus.cfg_c;
        end
    end

    // Pending counter mask: loaded on accept, one bit retired per taken C write.
    always_ff @(posedge refclk) begin
        if (rst)                                 r_mask <= '0;
        else if (w_accept)                       r_mask <= bus.cfg_c_mask;
        else if (r_state == S_WR_C && w_wr_ack)  r_mask <= w_mask_rest;
    end

    // Settle and lock-timeout counters; timeout counter saturates instead of wrapping.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_scnt <= '0;
            r_tcnt <= '0;
        end else begin
            r_scnt <= (r_state == S_SETTLE) ? r_scnt + 1'b1 : '0;
            if (r_state != S_LOCKWAIT)  r_tcnt <= '0;
            else if (r_tcnt != TO_MAX)  r_tcnt <= r_tcnt + 1'b1;
        end
    end

    // Error flag: set on lock timeout, held until the next accepted setting.
    always_ff @(posedge refclk) begin
        if (rst)                                                         r_error <= 1'b0;
        else if (w_accept)                                               r_error <= 1'b0;
        else if (r_state == S_LOCKWAIT && !r_lk_sync && r_tcnt == TO_LAST) r_error <= 1'b1;
    end

    // Two-flop synchroniser for the asynchronous lock indicator.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_lk_meta <= 1'b0;
            r_lk_sync <= 1'b0;
        end else begin
            r_lk_meta <= pll_locked;
            r_lk_sync <= r_lk_meta;
        end
    end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Purpose : directed table-driven bench for pll_reconfig_seq (frac and non-frac instances).
// Latency : n/a.
// Backpressure: bench plays the reconfig core and inserts waitrequest cycles per vector.
module tb_pll_reconfig_seq;
    localparam int NC     = 4;
    localparam int SETTLE = 16;
    localparam int TMO    = 100;

    logic refclk = 1'b0;
    always #5 refclk = ~refclk;

    logic          rst;
    logic          sel;            // 0: frac instance, 1: non-frac instance
    logic          cfg_valid;
    logic [17:0]   cfg_n, cfg_m;
    logic [31:0]   cfg_k;
    logic [71:0]   cfg_c;
    logic [3:0]    cfg_mask;
    logic          waitreq;
    logic          pll_locked;
    int            wait_len;
    int            lock_plan;      // 0: low with glitch in settle, 1: rise 5 cycles into lock wait, 2: high

    logic busy_a, done_a, error_a, busy_b, done_b, error_b;

    pll_reconfig_seq_if #(.NUM_CLOCKS(NC)) if_a ();
    pll_reconfig_seq_if #(.NUM_CLOCKS(NC)) if_b ();

    assign if_a.cfg_valid = cfg_valid & ~sel;
    assign if_a.cfg_n = cfg_n;  assign if_a.cfg_m = cfg_m;  assign if_a.cfg_k = cfg_k;
    assign if_a.cfg_c = cfg_c;  assign if_a.cfg_c_mask = cfg_mask;
    assign if_a.mgmt_waitrequest = waitreq;
    assign if_b.cfg_valid = cfg_valid & sel;
    assign if_b.cfg_n = cfg_n;  assign if_b.cfg_m = cfg_m;  assign if_b.cfg_k = cfg_k;
    assign if_b.cfg_c = cfg_c;  assign if_b.cfg_c_mask = cfg_mask;
    assign if_b.mgmt_waitrequest = waitreq;

    pll_reconfig_seq #(.NUM_CLOCKS(NC), .USE_FRAC(1), .SETTLE_CYC(SETTLE), .LOCK_TIMEOUT(TMO)) u_dut_a (
        .refclk(refclk), .rst(rst), .bus(if_a.slave), .pll_locked(pll_locked),
        .busy(busy_a), .done(done_a), .error(error_a));
    pll_reconfig_seq #(.NUM_CLOCKS(NC), .USE_FRAC(0), .SETTLE_CYC(SETTLE), .LOCK_TIMEOUT(TMO)) u_dut_b (
        .refclk(refclk), .rst(rst), .bus(if_b.slave), .pll_locked(pll_locked),
        .busy(busy_b), .done(done_b), .error(error_b));

    logic        m_ready, m_write, m_busy, m_done, m_error;
    logic [5:0]  m_addr;
    logic [31:0] m_data;
    assign m_ready = sel ? if_b.cfg_ready      : if_a.cfg_ready;
    assign m_write = sel ? if_b.mgmt_write     : if_a.mgmt_write;
    assign m_addr  = sel ? if_b.mgmt_address   : if_a.mgmt_address;
    assign m_data  = sel ? if_b.mgmt_writedata : if_a.mgmt_writedata;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_done  = sel ? done_b  : done_a;
    assign m_error = sel ? error_b : error_a;

    // Monitor / reconfig-core model, evaluated mid-cycle.
    int          cyc = 0;
    int          hold = 0;
    int          unstable = 0;
    int          last_start = 0;
    bit          armed = 0;
    logic [5:0]  h_a;
    logic [31:0] h_d;
    logic [5:0]  rec_a[$];
    logic [31:0] rec_d[$];
    int          rec_h[$];
    int          rec_c[$];
    int          acc_q[$];
    int          done_q[$];
    bit          done_e[$];

    always @(negedge refclk) begin
        cyc = cyc + 1;
        if (cfg_valid === 1'b1 && m_ready === 1'b1) begin
            acc_q.push_back(cyc);
            armed = 0;
        end
        if (m_write === 1'b1) begin
            if (hold == 0) begin
                h_a = m_addr;
                h_d = m_data;
            end else if (m_addr !== h_a || m_data !== h_d) begin
                unstable = unstable + 1;
            end
            if (hold < wait_len) begin
                waitreq = 1'b1;
                hold = hold + 1;
            end else begin
                waitreq = 1'b0;
                rec_a.push_back(m_addr);
                rec_d.push_back(m_data);
                rec_h.push_back(hold + 1);
                rec_c.push_back(cyc);
                if (m_addr == 6'h02) begin
                    last_start = cyc;
                    armed = 1;
                end
                hold = 0;
            end
        end else begin
            waitreq = 1'b0;
            hold = 0;
        end
        if (m_done === 1'b1) begin
            done_q.push_back(cyc);
            done_e.push_back(m_error);
        end
        case (lock_plan)
            2:       pll_locked = 1'b1;
            1:       pll_locked = armed && (cyc >= last_start + 22);
            default: pll_locked = armed && (cyc >= last_start + 5) && (cyc <= last_start + 7);
        endcase
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // Expected write list straight from the register map.
    logic [5:0]  exp_a[$];
    logic [31:0] exp_d[$];
    task automatic build_exp(input bit nf, input logic [17:0] n, input logic [17:0] m,
                             input logic [31:0] k, input logic [71:0] c, input logic [3:0] mask);
        exp_a.delete(); exp_d.delete();
        exp_a.push_back(6'h00); exp_d.push_back(32'd0);
        exp_a.push_back(6'h03); exp_d.push_back({14'b0, n});
        exp_a.push_back(6'h04); exp_d.push_back({14'b0, m});
        if (!nf) begin exp_a.push_back(6'h07); exp_d.push_back(k); end
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                exp_a.push_back(6'h05);
                exp_d.push_back({9'b0, 5'(i), c[18*i +: 18]});
            end
        end
        exp_a.push_back(6'h02); exp_d.push_back(32'd1);
    endtask

    task automatic cmp_writes(input string tag, input int base, input int wl);
        for (int i = 0; i < exp_a.size(); i++) begin
            if (base + i < rec_a.size()) begin
                chk($sformatf("%s_addr%0d", tag, i), 64'(rec_a[base+i]), 64'(exp_a[i]));
                chk($sformatf("%s_data%0d", tag, i), 64'(rec_d[base+i]), 64'(exp_d[i]));
                chk($sformatf("%s_hold%0d", tag, i), 64'(rec_h[base+i]), 64'(wl + 1));
            end
        end
    endtask

    // Waits until at least 'target' accepts were seen; false on expiry.
    task automatic wait_acc(input int target, input int budget, output bit ok);
        ok = 0;
        for (int t = 0; t < budget; t++) begin
            @(negedge refclk); #1;
            if (acc_q.size() >= target) begin ok = 1; break; end
        end
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        ok = 0;
        for (int t = 0; t < budget; t++) begin
            @(negedge refclk); #1;
            if (done_q.size() >= target) begin ok = 1; break; end
        end
    endtask

    typedef struct {
        bit          nf;
        logic [3:0]  mask;
        int          wl;
        int          plan;
        logic [17:0] n;
        logic [17:0] m;
        logic [31:0] k;
        logic [71:0] c;
        int          exp_nwr;
        int          exp_dly;   // START acceptance to done pulse
        bit          exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input int vi, input vec_t v);
        int base, nacc, ndone, u0;
        bit ok;
        base = rec_a.size(); nacc = acc_q.size(); ndone = done_q.size(); u0 = unstable;
        build_exp(v.nf, v.n, v.m, v.k, v.c, v.mask);
        @(posedge refclk); #1;
        sel = v.nf; wait_len = v.wl; lock_plan = v.plan;
        cfg_n = v.n; cfg_m = v.m; cfg_k = v.k; cfg_c = v.c; cfg_mask = v.mask;
        cfg_valid = 1'b1;
        wait_acc(nacc + 1, 20, ok);
        if (!ok) begin bound_fail($sformatf("v%0d_accept", vi)); cfg_valid = 1'b0; return; end
        @(posedge refclk); #1;
        cfg_valid = 1'b0;
        chk($sformatf("v%0d_busy_after_acc", vi), 64'(m_busy), 64'(1));
        chk($sformatf("v%0d_err_cleared", vi), 64'(m_error), 64'(0));
        chk($sformatf("v%0d_ready_busy", vi), 64'(m_ready), 64'(0));
        cfg_n = ~v.n; cfg_m = ~v.m; cfg_k = ~v.k; cfg_c = ~v.c; cfg_mask = ~v.mask;
        wait_done(ndone + 1, 400, ok);
        if (!ok) begin bound_fail($sformatf("v%0d_done", vi)); return; end
        repeat (3) begin @(negedge refclk); #1; end
        chk($sformatf("v%0d_nwr", vi), 64'(rec_a.size() - base), 64'(v.exp_nwr));
        cmp_writes($sformatf("v%0d", vi), base, v.wl);
        chk($sformatf("v%0d_stable", vi), 64'(unstable - u0), 64'(0));
        chk($sformatf("v%0d_done_dly", vi), 64'(done_q[ndone] - rec_c[rec_c.size()-1]), 64'(v.exp_dly));
        chk($sformatf("v%0d_err_at_done", vi), 64'(done_e[ndone]), 64'(v.exp_err));
        chk($sformatf("v%0d_one_done", vi), 64'(done_q.size() - ndone), 64'(1));
        chk($sformatf("v%0d_err_held", vi), 64'(m_error), 64'(v.exp_err));
        chk($sformatf("v%0d_ready_idle", vi), 64'(m_ready), 64'(1));
        chk($sformatf("v%0d_busy_idle", vi), 64'(m_busy), 64'(0));
    endtask

    initial begin
        bit ok;
        int base, nacc, ndone, d1;
        rst = 1'b1; sel = 1'b0; cfg_valid = 1'b0; wait_len = 0; lock_plan = 0;
        cfg_n = '0; cfg_m = '0; cfg_k = '0; cfg_c = '0; cfg_mask = '0;

        // nf mask wl plan n m k c nwr dly err
        vecs[0] = '{1'b0, 4'b0101, 0, 1, 18'h20302, 18'h01414, 32'h8000_0000,
                    {18'h00505, 18'h20403, 18'h10101, 18'h00A0B}, 7, 25, 1'b0};
        vecs[1] = '{1'b0, 4'b0101, 3, 1, 18'h00101, 18'h21010, 32'h1234_5678,
                    {18'h3FFFF, 18'h0C0C0, 18'h2AAAA, 18'h15555}, 7, 25, 1'b0};
        vecs[2] = '{1'b0, 4'b1111, 0, 0, 18'h10000, 18'h00808, 32'hDEAD_BEEF,
                    {18'h00404, 18'h00303, 18'h00202, 18'h00101}, 9, 117, 1'b1};
        vecs[3] = '{1'b0, 4'b1000, 1, 1, 18'h00202, 18'h00606, 32'h0000_0000,
                    {18'h21213, 18'h00001, 18'h00002, 18'h00003}, 6, 25, 1'b0};
        vecs[4] = '{1'b1, 4'b0000, 0, 1, 18'h00505, 18'h00A0A, 32'hFFFF_FFFF,
                    {18'h11111, 18'h22222, 18'h33333, 18'h00444}, 4, 25, 1'b0};
        vecs[5] = '{1'b1, 4'b1010, 2, 0, 18'h30F0F, 18'h0F0F0, 32'h5555_AAAA,
                    {18'h0ABCD, 18'h01234, 18'h3FEDC, 18'h00777}, 6, 117, 1'b1};

        repeat (3) @(posedge refclk);
        #1;
        chk("rst_ready", 64'(m_ready), 64'(0));
        chk("rst_write", 64'(m_write), 64'(0));
        chk("rst_addr",  64'(m_addr),  64'(0));
        chk("rst_data",  64'(m_data),  64'(0));
        chk("rst_busy",  64'(m_busy),  64'(0));
        chk("rst_done",  64'(m_done),  64'(0));
        chk("rst_error", 64'(m_error), 64'(0));
        rst = 1'b0;
        @(negedge refclk); #1;
        chk("post_rst_ready", 64'(m_ready), 64'(1));

        for (int vi = 0; vi < 6; vi++) run_vec(vi, vecs[vi]);

        // Reset while the second C counter write is on the bus.
        sel = 1'b0; wait_len = 0; lock_plan = 0;
        base = rec_a.size(); nacc = acc_q.size(); ndone = done_q.size();
        @(posedge refclk); #1;
        cfg_n = 18'h00303; cfg_m = 18'h00404; cfg_k = 32'h1; cfg_c = 72'h0; cfg_mask = 4'b0101;
        cfg_valid = 1'b1;
        wait_acc(nacc + 1, 20, ok);
        @(posedge refclk); #1;
        cfg_valid = 1'b0;
        ok = 0;
        for (int t = 0; t < 30; t++) begin
            if (rec_a.size() >= base + 5) begin ok = 1; break; end
            @(negedge refclk); #1;
        end
        if (!ok) bound_fail("rst_mid_c0");
        @(posedge refclk); #1;
        chk("rst_mid_c2_write", 64'(m_write), 64'(1));
        chk("rst_mid_c2_addr",  64'(m_addr),  64'(5));
        rst = 1'b1;
        #1;
        chk("rst_mid_write_drop", 64'(m_write), 64'(0));
        @(posedge refclk); #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_write", 64'(m_write), 64'(0));
        chk("rst_mid_busy",  64'(m_busy),  64'(0));
        chk("rst_mid_ready", 64'(m_ready), 64'(1));
        repeat (40) @(negedge refclk);
        #1;
        chk("rst_mid_nwr",     64'(rec_a.size() - base), 64'(5));
        chk("rst_mid_no_done", 64'(done_q.size() - ndone), 64'(0));

        // cfg_valid held high across two settings; inputs change mid-sequence.
        sel = 1'b0; wait_len = 0; lock_plan = 2;
        base = rec_a.size(); nacc = acc_q.size(); ndone = done_q.size();
        @(posedge refclk); #1;
        cfg_n = 18'h00A01; cfg_m = 18'h00B02; cfg_k = 32'hCAFE_0001;
        cfg_c = {18'h0, 18'h0, 18'h12345, 18'h2ABCD}; cfg_mask = 4'b0011;
        cfg_valid = 1'b1;
        wait_acc(nacc + 1, 20, ok);
        if (!ok) bound_fail("b2b_acc1");
        @(posedge refclk); #1;
        cfg_n = 18'h00C03; cfg_m = 18'h00D04; cfg_k = 32'hBEEF_0002;
        cfg_c = {18'h3AAAA, 18'h05555, 18'h0, 18'h0}; cfg_mask = 4'b1100;
        wait_done(ndone + 1, 300, ok);
        if (!ok) bound_fail("b2b_done1");
        chk("b2b_acc_count_before_done", 64'(acc_q.size() - nacc), 64'(1));
        wait_acc(nacc + 2, 20, ok);
        if (!ok) bound_fail("b2b_acc2");
        @(posedge refclk); #1;
        cfg_valid = 1'b0;
        if (ok && done_q.size() > ndone) begin
            d1 = done_q[ndone];
            chk("b2b_acc2_after_done", 64'(acc_q[nacc+1]), 64'(d1 + 1));
        end
        build_exp(1'b0, 18'h00A01, 18'h00B02, 32'hCAFE_0001,
                  {18'h0, 18'h0, 18'h12345, 18'h2ABCD}, 4'b0011);
        cmp_writes("b2b_s1", base, 0);
        wait_done(ndone + 2, 300, ok);
        if (!ok) bound_fail("b2b_done2");
        chk("b2b_nwr", 64'(rec_a.size() - base), 64'(14));
        build_exp(1'b0, 18'h00C03, 18'h00D04, 32'hBEEF_0002,
                  {18'h3AAAA, 18'h05555, 18'h0, 18'h0}, 4'b1100);
        cmp_writes("b2b_s2", base + 7, 0);
        if (done_e.size() >= ndone + 2)
            chk("b2b_err2", 64'(done_e[ndone+1]), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end
endmodule
